// File: rtl/hex_word_tx_pkg.sv
`default_nettype none
// ============================================================================
// hex_pkg : ASCII constants, FSM states and nibble-to-ASCII helper for hex_word_tx
// Revision: 1.0
// ============================================================================
package hex_pkg;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_LC_X = 8'h78;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PFX0 = 3'd1,
    ST_PFX1 = 3'd2,
    ST_DIG  = 3'd3,
    ST_CR   = 3'd4,
    ST_LF   = 3'd5
  } state_t;

  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nibble, input logic upper);
    logic [7:0] n8;
    n8 = {4'h0, nibble};
    if (nibble < 4'd10) return ASCII_ZERO + n8;
    else if (upper)     return 8'h37 + n8;   // 'A' - 10
    else                return 8'h57 + n8;   // 'a' - 10
  endfunction

endpackage
`default_nettype wire

// File: rtl/hex_word_tx.sv
`default_nettype none
// ============================================================================
// hex_word_tx : formats binary words as ASCII hex lines on a byte stream
// Revision: 1.0
// ============================================================================
module hex_word_tx
  import hex_pkg::*;
#(
  parameter int WORD_WIDTH = 16,
  parameter int PREFIX     = 0,
  parameter int EOL        = 2,
  parameter int UPPER      = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_WIDTH-1:0] word_data,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic [7:0]            out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy
);

  localparam int DIGITS = WORD_WIDTH / 4;
  localparam int CW     = $clog2(DIGITS + 1);

  state_t                state, state_nx;
  logic [WORD_WIDTH-1:0] shreg;
  logic [CW-1:0]         cnt;
  logic                  accept;
  logic                  xfer;

  assign accept = word_valid && word_ready;
  assign xfer   = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        shreg <= word_data;
        cnt   <= CW'(DIGITS);
      end else if (xfer && state == ST_DIG) begin
        shreg <= shreg << 4;
        cnt   <= cnt - 1'b1;
      end
    end
  end

  // Outputs decode from registered state only, so out_valid never sees out_ready.
  always_comb begin
    state_nx   = state;
    word_ready = 1'b0;
    out_valid  = 1'b0;
    out_data   = 8'h00;
    busy       = 1'b1;
    case (state)
      ST_IDLE: begin
        word_ready = 1'b1;
        busy       = 1'b0;
        if (word_valid) state_nx = (PREFIX != 0) ? ST_PFX0 : ST_DIG;
      end
      ST_PFX0: begin
        out_valid = 1'b1;
        out_data  = ASCII_ZERO;
        if (out_ready) state_nx = ST_PFX1;
      end
      ST_PFX1: begin
        out_valid = 1'b1;
        out_data  = ASCII_LC_X;
        if (out_ready) state_nx = ST_DIG;
      end
      ST_DIG: begin
        out_valid = 1'b1;
        out_data  = nibble_to_ascii(shreg[WORD_WIDTH-1 -: 4], UPPER != 0);
        if (out_ready && cnt == CW'(1))
          state_nx = (EOL == 2) ? ST_CR : (EOL == 1) ? ST_LF : ST_IDLE;
      end
      ST_CR: begin
        out_valid = 1'b1;
        out_data  = ASCII_CR;
        if (out_ready) state_nx = ST_LF;
      end
      ST_LF: begin
        out_valid = 1'b1;
        out_data  = ASCII_LF;
        if (out_ready) state_nx = ST_IDLE;
      end
      default: begin
        busy     = 1'b0;
        state_nx = ST_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_hex_word_tx.sv
`default_nettype none
// Directed bench for hex_word_tx: three instances cover default, prefix/lowercase/LF
// and 8-bit/no-terminator configurations.
module tb_hex_word_tx;

  logic        clk;
  logic        rst;
  logic [31:0] wdata [3];
  logic        wv    [3];
  logic        wr    [3];
  logic [7:0]  od    [3];
  logic        ov    [3];
  logic        ordy  [3];
  logic        bsy   [3];

  int checks = 0;
  int errors = 0;

  hex_word_tx #(.WORD_WIDTH(16), .PREFIX(0), .EOL(2), .UPPER(1)) u_def (
    .clk(clk), .rst(rst), .word_data(wdata[0][15:0]), .word_valid(wv[0]),
    .word_ready(wr[0]), .out_data(od[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
    .busy(bsy[0]));

  hex_word_tx #(.WORD_WIDTH(16), .PREFIX(1), .EOL(1), .UPPER(0)) u_pfx (
    .clk(clk), .rst(rst), .word_data(wdata[1][15:0]), .word_valid(wv[1]),
    .word_ready(wr[1]), .out_data(od[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
    .busy(bsy[1]));

  hex_word_tx #(.WORD_WIDTH(8), .PREFIX(0), .EOL(0), .UPPER(1)) u_w8 (
    .clk(clk), .rst(rst), .word_data(wdata[2][7:0]), .word_valid(wv[2]),
    .word_ready(wr[2]), .out_data(od[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
    .busy(bsy[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge while idle; returns at the negedge after the accept edge.
  task automatic send_word(input int d, input logic [31:0] w);
    chk("word_ready_idle", 32'(wr[d]), 1);
    wdata[d] = w;
    wv[d]    = 1'b1;
    @(negedge clk);
    wv[d]    = 1'b0;
    chk("first_byte_latency", 32'(ov[d]), 1);
    chk("word_ready_busy", 32'(wr[d]), 0);
  endtask

  // Expects n bytes (exp holds them MSB-first); checks data on every valid cycle so a
  // stalled byte must stay put and no byte may be skipped or repeated.
  task automatic recv(input int d, input logic [127:0] exp, input int n, input bit rnd,
                      output int cyc);
    int i;
    int wait_c;
    logic [7:0] e;
    i = 0; cyc = 0; wait_c = 0;
    while (i < n && wait_c <= 64) begin
      e = exp[8*(n-1-i) +: 8];
      ordy[d] = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      chk("busy_in_line", 32'(bsy[d]), 1);
      if (ov[d]) chk("byte", 32'(od[d]), 32'(e));
      if (ov[d] && ordy[d]) begin
        i++;
        wait_c = 0;
      end else begin
        wait_c++;
      end
      cyc++;
      @(negedge clk);
    end
    ordy[d] = 1'b1;
    chk("byte_count", i, n);
  endtask

  initial begin
    int cyc;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wdata[k] = '0; wv[k] = 1'b0; ordy[k] = 1'b1;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_word_ready", 32'(wr[k]), 1);
      chk("rst_out_valid", 32'(ov[k]), 0);
      chk("rst_out_data", 32'(od[k]), 0);
      chk("rst_busy", 32'(bsy[k]), 0);
    end
    rst = 1'b1;
    @(negedge clk);

    // BEEF, full throughput
    send_word(0, 32'hBEEF);
    recv(0, 128'h42_45_45_46_0D_0A, 6, 1'b0, cyc);
    chk("beef_cycles", cyc, 6);
    chk("beef_ready_after", 32'(wr[0]), 1);
    chk("beef_idle_valid", 32'(ov[0]), 0);

    // prefix, lowercase, LF only
    send_word(1, 32'h0A5C);
    recv(1, 128'h30_78_30_61_35_63_0A, 7, 1'b0, cyc);
    chk("pfx_cycles", cyc, 7);
    chk("pfx_ready_after", 32'(wr[1]), 1);

    // random backpressure
    send_word(0, 32'h1234);
    recv(0, 128'h31_32_33_34_0D_0A, 6, 1'b1, cyc);
    chk("stall_ready_after", 32'(wr[0]), 1);

    // back-to-back with word_valid held
    wdata[0] = 32'h0000; wv[0] = 1'b1;
    @(negedge clk);
    wdata[0] = 32'hFFFF;
    chk("b2b_ready_busy", 32'(wr[0]), 0);
    recv(0, 128'h30_30_30_30_0D_0A, 6, 1'b0, cyc);
    chk("b2b_gap_valid", 32'(ov[0]), 0);
    chk("b2b_gap_ready", 32'(wr[0]), 1);
    @(negedge clk);
    wv[0] = 1'b0;
    chk("b2b_second_latency", 32'(ov[0]), 1);
    recv(0, 128'h46_46_46_46_0D_0A, 6, 1'b0, cyc);
    chk("b2b_cycles", cyc, 6);
    chk("b2b_idle_valid", 32'(ov[0]), 0);

    // reset mid-line
    send_word(0, 32'hCAFE);
    recv(0, 128'h43_41, 2, 1'b0, cyc);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("midrst_valid", 32'(ov[0]), 0);
    chk("midrst_ready", 32'(wr[0]), 1);
    chk("midrst_busy", 32'(bsy[0]), 0);
    @(negedge clk);
    chk("midrst_still_idle", 32'(ov[0]), 0);
    send_word(0, 32'h0001);
    recv(0, 128'h30_30_30_31_0D_0A, 6, 1'b0, cyc);
    chk("post_rst_cycles", cyc, 6);

    // 8-bit word, no terminator
    chk("w8_busy_before", 32'(bsy[2]), 0);
    send_word(2, 32'h7F);
    recv(2, 128'h37_46, 2, 1'b0, cyc);
    chk("w8_cycles", cyc, 2);
    chk("w8_busy_after", 32'(bsy[2]), 0);
    chk("w8_ready_after", 32'(wr[2]), 1);
    chk("w8_valid_after", 32'(ov[2]), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hex_word_tx.md
Name: hex_word_tx

Overview:
- Device-to-host formatter for the USB serial byte pipeline.
- Accepts binary words over a valid/ready handshake.
- Emits each word as ASCII hex text with an optional "0x" prefix and a line terminator, one byte at a time.
- Its byte output drives the uart_in_data/valid/ready pipeline, the host-bound direction. It is the transmit counterpart to blocks that consume the host-to-device byte stream.

Parameters:
- WORD_WIDTH, 16: input word width in bits; must be a multiple of 4, range 4..32.
- PREFIX, 0: 1 emits "0x" before the digits.
- EOL, 2: line terminator; 0 = none, 1 = LF, 2 = CR LF.
- UPPER, 1: 1 emits hex digits A-F in upper case, 0 emits a-f.

Ports:
- clk, input, 1: 48 MHz system clock; all logic on rising edge.
- rst, input, 1: synchronous, active-low reset.
- word_data, input, WORD_WIDTH: word to print.
- word_valid, input, 1: word_data is valid.
- word_ready, output, 1: block can accept a word this cycle.
- out_data, output, 8: ASCII byte toward the host (to uart_in_data).
- out_valid, output, 1: out_data is valid (to uart_in_valid).
- out_ready, input, 1: downstream accepts the byte (from uart_in_ready).
- busy, output, 1: a word is being formatted or emitted.

Behaviour:
- Reset (rst low at a clock edge): state IDLE, out_valid 0, out_data 8'h00, word_ready 1, busy 0, counters cleared.
- Reset mid-word: the partial line is abandoned with no terminator. out_valid is 0 from the cycle after the reset edge.
- Word handshake: a transfer occurs on a cycle with word_valid and word_ready both high.
  - word_ready = (state == IDLE); combinational from state only, never from word_valid.
  - The accepted word is latched into a shift register.
- Byte handshake: a transfer occurs on a cycle with out_valid and out_ready both high.
  - Once raised, out_valid stays high and out_data stays stable until the transfer.
  - out_valid never depends combinationally on out_ready.
- States:
  - IDLE: on word accept, go to PFX0 if PREFIX=1, else to DIG. out_valid rises the next cycle, so latency from accept to first byte valid is 1 cycle.
  - PFX0: presents "0" (8'h30); on transfer go to PFX1.
  - PFX1: presents "x" (8'h78); on transfer go to DIG.
  - DIG: presents the ASCII of the top nibble.
    - On transfer: shift left by 4 and decrement the digit counter (init WORD_WIDTH/4).
    - On the last digit: go to CR if EOL=2, LF if EOL=1, IDLE if EOL=0.
  - CR: presents 8'h0D; on transfer go to LF.
  - LF: presents 8'h0A; on transfer go to IDLE.
- Nibble mapping: 0-9 map to 8'h30-8'h39; 10-15 map to 8'h41-8'h46 (UPPER=1) or 8'h61-8'h66 (UPPER=0).
- Throughput:
  - With out_ready held high, one byte transfers per cycle.
  - The next byte is presented in the cycle after each transfer.
  - Bytes per word = 2*PREFIX + WORD_WIDTH/4 + EOL.
- Back-to-back words:
  - After the final byte transfers, state returns to IDLE and word_ready is 1 in the following cycle.
  - A new word accepted then presents its first byte one cycle later.
  - One idle byte slot between lines is allowed.
- busy = (state != IDLE).
- Stalls: out_ready low for any duration freezes state and out_data. No byte is skipped or duplicated.
- word_valid while busy: ignored with no effect. The upstream producer must hold the word until word_ready.

Decomposition:
- Package hex_pkg:
  - ASCII constants: ZERO 8'h30, LC_X 8'h78, CR 8'h0D, LF 8'h0A.
  - Function nibble_to_ascii(nibble, upper).
  - State encoding constants: IDLE, PFX0, PFX1, DIG, CR, LF.
- Single module; no sub-module needed. The nibble mapping lives in the package function.

Test Plan:
- Default parameters, out_ready=1, word 16'hBEEF: bytes 42 45 45 46 0D 0A on consecutive cycles; first byte one cycle after accept; word_ready returns 1 after the 0A transfer.
- PREFIX=1, UPPER=0, EOL=1, word 16'h0A5c: bytes 30 78 30 61 35 63 0A; 7 bytes total.
- Default parameters, word 16'h1234, out_ready toggling 1,0,0,1,... pseudo-randomly: bytes exactly 31 32 33 34 0D 0A; out_data stable whenever out_valid=1 and out_ready=0.
- Two words 16'h0000 and 16'hFFFF offered back-to-back with word_valid held: the second word is accepted only once word_ready is 1 after the first line; stream is 30 30 30 30 0D 0A 46 46 46 46 0D 0A.
- rst low for 1 cycle after the 2nd byte of 16'hCAFE: out_valid=0, word_ready=1 on the next cycle; a subsequent word 16'h0001 emits 30 30 30 31 0D 0A cleanly.
- WORD_WIDTH=8, EOL=0, word 8'h7F: bytes 37 46 only, then IDLE; busy high for exactly the emission window.
